// File: rtl/link_pkg.sv
// Shared serial-link definitions used by both the transmit and receive ends.
// Holds the packet/frame sizes, the FSM state encoding and the parity sense.
package link_pkg;

  localparam int PKT_W      = 55;
  localparam int FRAME_BITS = 57;
  localparam bit PARITY_ODD = 1'b1;
  localparam int CNT_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } link_state_e;

endpackage

// File: rtl/transmitter_if.sv
// Packet handshake between the router core (master) and the transmitter (slave).
// A packet moves on a rising edge where TX_Data_Valid && TX_Ready; the source holds
// valid and data stable until that edge, and TX_Ready does not depend on valid.
interface transmitter_if #(
    parameter int DATA_W = 55
);
    logic              TX_Data_Valid;
    logic [DATA_W-1:0] TX_Data;
    logic              TX_Ready;

    modport master (output TX_Data_Valid, output TX_Data, input TX_Ready);
    modport slave  (input TX_Data_Valid, input TX_Data, output TX_Ready);
endinterface

// File: rtl/transmit_protocol.sv
// Serializer datapath: shift register, bit counter, parity register and the S_Data flop.
// Each edge sets S_Data to the value belonging to the state that starts on that edge.
module transmit_protocol
    import link_pkg::*;
#(
    parameter int DATA_W = PKT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  link_state_e       state,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              last_bit,
    output logic              s_data
);

    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              parity_q;

    assign last_bit = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            s_data   <= 1'b0;
        end else begin
            s_data <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shift_q  <= data;
                        parity_q <= PARITY_ODD ? ~^data : ^data;
                        s_data   <= 1'b1;
                    end
                end
                ST_START: begin
                    s_data  <= shift_q[DATA_W-1];
                    shift_q <= shift_q << 1;
                    cnt_q   <= CNT_W'(DATA_W - 1);
                end
                ST_DATA: begin
                    // cnt_q counts the bits still to follow the one on the line now
                    if (cnt_q != '0) begin
                        s_data  <= shift_q[DATA_W-1];
                        shift_q <= shift_q << 1;
                        cnt_q   <= cnt_q - 1'b1;
                    end else begin
                        s_data <= parity_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/transmitter.sv
// Serial transmit stage: accepts a packet over the handshake, then frames it on S_Data
// as start bit, MSB-first data, odd parity and a forced-low idle gap.
module transmitter
    import link_pkg::*;
#(
    parameter int DATA_W  = PKT_W,
    parameter int GAP_CYC = 2
) (
    input  logic         Clk_S,
    input  logic         Rst_n,
    transmitter_if.slave tx,
    output logic         S_Data,
    output link_state_e  dbg_state
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    link_state_e      state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ready;
    logic             accept;
    logic             last_bit;

    assign ready       = (state_q == ST_IDLE);
    assign tx.TX_Ready = ready;
    assign accept      = tx.TX_Data_Valid && ready;
    assign dbg_state   = state_q;

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE:   state_d = accept ? ST_START : ST_IDLE;
            ST_START:  state_d = ST_DATA;
            ST_DATA:   state_d = last_bit ? ST_PARITY : ST_DATA;
            ST_PARITY: begin
                state_d = ST_GAP;
                gap_d   = GAP_W'(GAP_CYC - 1);
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = gap_q - 1'b1;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    transmit_protocol #(
        .DATA_W(DATA_W)
    ) u_protocol (
        .clk     (Clk_S),
        .rst_n   (Rst_n),
        .state   (state_q),
        .load    (accept),
        .data    (tx.TX_Data),
        .last_bit(last_bit),
        .s_data  (S_Data)
    );

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for the transmitter: reset, frame content, back-to-back, input
// isolation after acceptance and reset in the middle of a frame.
module tb_transmitter;
    import link_pkg::*;

    localparam int W   = 55;
    localparam int GAP = 2;
    localparam int FR  = 1 + W + 1 + GAP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_data;
    link_state_e dbg_state;
    int          total = 0;
    int          bad = 0;

    transmitter_if #(.DATA_W(W)) tx_bus ();

    transmitter #(
        .DATA_W (W),
        .GAP_CYC(GAP)
    ) dut (
        .Clk_S    (clk),
        .Rst_n    (rst_n),
        .tx       (tx_bus),
        .S_Data   (s_data),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Presents d with valid high and returns just after the accepting edge.
    task automatic start_tx(input logic [W-1:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        tx_bus.TX_Data_Valid = 1'b1;
        tx_bus.TX_Data       = d;
        for (int i = 0; i < 200; i++) begin
            if (tx_bus.TX_Ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Records the line over cycles N+1..N+FR, then samples ready in cycle N+FR+1.
    task automatic capture(input bit keep_valid, input bit scramble,
                           input logic [W-1:0] next_data,
                           output logic [FR-1:0] line, output int low_cnt,
                           output logic ready_after);
        logic [63:0] r;
        line    = '0;
        low_cnt = 0;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            line[FR-1-i] = s_data;
            if (tx_bus.TX_Ready === 1'b0) low_cnt++;
            if (scramble) begin
                r = {$urandom(), $urandom()};
                tx_bus.TX_Data       = r[W-1:0];
                tx_bus.TX_Data_Valid = 1'($urandom_range(0, 1));
            end else if (keep_valid) begin
                tx_bus.TX_Data = next_data;
            end else begin
                tx_bus.TX_Data_Valid = 1'b0;
            end
        end
        @(negedge clk);
        ready_after = tx_bus.TX_Ready;
    endtask

    task automatic test_reset();
        tx_bus.TX_Data_Valid = 1'b0;
        tx_bus.TX_Data       = '0;
        rst_n = 1'b0;
        #12;
        total++;
        if (s_data !== 1'b0 || tx_bus.TX_Ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold s_data=%b ready=%b exp s_data=0 ready=1", s_data, tx_bus.TX_Ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (s_data !== 1'b0 || tx_bus.TX_Ready !== 1'b1 || dbg_state !== ST_IDLE) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d s_data=%b ready=%b state=%0d exp 0/1/0",
                         i, s_data, tx_bus.TX_Ready, dbg_state);
            end
        end
    endtask

    task automatic test_all_ones();
        logic [W-1:0]  pkt;
        logic [FR-1:0] line, exp;
        int            low;
        logic          rdy;
        bit            ok;
        pkt = 55'h7F_FFFF_FFFF_FFFF;
        exp = {1'b1, pkt, 1'b0, 2'b00};
        start_tx(pkt, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL all_ones_accept got=0 exp=1"); end
        capture(1'b0, 1'b0, '0, line, low, rdy);
        total++;
        if (line !== exp) begin bad++; $display("FAIL all_ones_line got=%h exp=%h", line, exp); end
        total++;
        if (low !== 59) begin bad++; $display("FAIL all_ones_ready_low got=%0d exp=59", low); end
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL all_ones_ready_back got=%b exp=1", rdy); end
    endtask

    task automatic test_sparse();
        logic [W-1:0]  pkt;
        logic [FR-1:0] line, exp;
        int            low;
        logic          rdy;
        bit            ok;
        pkt = 55'h40_0000_0000_0001;
        exp = {1'b1, pkt, 1'b1, 2'b00};
        start_tx(pkt, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL sparse_accept got=0 exp=1"); end
        capture(1'b0, 1'b0, '0, line, low, rdy);
        total++;
        if (line !== exp) begin bad++; $display("FAIL sparse_line got=%h exp=%h", line, exp); end
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL sparse_ready_back got=%b exp=1", rdy); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  pa, pb;
        logic [FR-1:0] line, exp_a, exp_b;
        int            low;
        logic          rdy;
        bit            ok;
        pa    = 55'h55_5555_5555_5555;
        pb    = 55'h2A_AAAA_AAAA_AAAA;
        exp_a = {1'b1, pa, 1'b1, 2'b00};
        exp_b = {1'b1, pb, 1'b0, 2'b00};
        start_tx(pa, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_accept got=0 exp=1"); end
        capture(1'b1, 1'b0, pb, line, low, rdy);
        total++;
        if (line !== exp_a) begin bad++; $display("FAIL b2b_first_line got=%h exp=%h", line, exp_a); end
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_ready_n60 got=%b exp=1", rdy); end
        // valid is still high here, so the next edge accepts the second packet
        capture(1'b0, 1'b0, '0, line, low, rdy);
        total++;
        if (line !== exp_b) begin bad++; $display("FAIL b2b_second_line got=%h exp=%h", line, exp_b); end
        total++;
        if (low !== 59) begin bad++; $display("FAIL b2b_second_ready_low got=%0d exp=59", low); end
    endtask

    task automatic test_data_change();
        logic [W-1:0]  pkt;
        logic [FR-1:0] line, exp;
        int            low;
        logic          rdy;
        bit            ok;
        pkt = 55'h0F_0F0F_0F0F_0F0F;
        exp = {1'b1, pkt, 1'b1, 2'b00};
        start_tx(pkt, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL change_accept got=0 exp=1"); end
        capture(1'b0, 1'b1, '0, line, low, rdy);
        tx_bus.TX_Data_Valid = 1'b0;
        total++;
        if (line !== exp) begin bad++; $display("FAIL change_line got=%h exp=%h", line, exp); end
        total++;
        if (low !== 59) begin bad++; $display("FAIL change_ready_low got=%0d exp=59", low); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0]  pkt;
        logic [FR-1:0] line, exp;
        int            low;
        logic          rdy;
        bit            ok;
        start_tx(55'h7F_FFFF_FFFF_FFFF, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_accept got=0 exp=1"); end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            tx_bus.TX_Data_Valid = 1'b0;
        end
        total++;
        if (s_data !== 1'b1) begin bad++; $display("FAIL midrst_line_before got=%b exp=1", s_data); end
        rst_n = 1'b0;
        #1;
        total++;
        if (s_data !== 1'b0 || tx_bus.TX_Ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL midrst_async s_data=%b ready=%b state=%0d exp 0/1/0",
                     s_data, tx_bus.TX_Ready, dbg_state);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (tx_bus.TX_Ready !== 1'b1 || s_data !== 1'b0) begin
            bad++;
            $display("FAIL midrst_release ready=%b s_data=%b exp 1/0", tx_bus.TX_Ready, s_data);
        end
        pkt = 55'h40_0000_0000_0001;
        exp = {1'b1, pkt, 1'b1, 2'b00};
        start_tx(pkt, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_next_accept got=0 exp=1"); end
        capture(1'b0, 1'b0, '0, line, low, rdy);
        total++;
        if (line !== exp) begin bad++; $display("FAIL midrst_next_line got=%h exp=%h", line, exp); end
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL midrst_next_ready got=%b exp=1", rdy); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_sparse();
        test_back_to_back();
        test_data_change();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
